// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wb_pkg
// Purpose  : Shared load funct3 encodings and default datapath width.
// Revision : 1.0
// ============================================================================
package wb_pkg;

    localparam int unsigned c_XLEN_DEFAULT = 32;

    typedef enum logic [2:0] {
        LD_LB  = 3'b000,
        LD_LH  = 3'b001,
        LD_LW  = 3'b010,
        LD_LBU = 3'b100,
        LD_LHU = 3'b101
    } ld_funct3_e;

endpackage
`default_nettype wire

// File: rtl/wb_ld_fifo.sv
`default_nettype none
// ============================================================================
// Module   : wb_ld_fifo
// Purpose  : Synchronous FIFO (any depth >= 2) holding extended load results.
// Revision : 1.0
// ============================================================================
module wb_ld_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       clrn,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam logic [PTR_W-1:0] c_LAST      = PTR_W'(DEPTH-1);
    localparam logic [CNT_W-1:0] c_DEPTH_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == c_DEPTH_CNT);
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && !o_empty;
    // A full FIFO can still take a push when the head leaves in the same cycle.
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk) begin
        if (!clrn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= (r_wr_ptr == c_LAST) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_LAST) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : wb_stage
// Purpose  : Writeback arbiter for ALU and load results; WB_LD_BUF_EN adds
//            an in-order load-response buffer (wb_ld_fifo).
// Revision : 1.0
// ============================================================================
module wb_stage
    import wb_pkg::*;
#(
    parameter int XLEN      = c_XLEN_DEFAULT,
    parameter int BUF_DEPTH = 2
) (
    input  logic                           clk,
    input  logic                           clrn,
    input  logic                           alu_valid,
    input  logic [4:0]                     alu_rd,
    input  logic [XLEN-1:0]                alu_data,
    input  logic                           ld_valid,
    output logic                           ld_ready,
    input  logic [4:0]                     ld_rd,
    input  logic [31:0]                    ld_data,
    input  logic [2:0]                     ld_funct3,
    input  logic [1:0]                     ld_addr_lo,
    output logic                           we,
    output logic [4:0]                     write_addr,
    output logic [XLEN-1:0]                result,
    output logic [$clog2(BUF_DEPTH+1)-1:0] buf_count
);

    logic            w_ld_acc;
    logic [7:0]      w_byte;
    logic [15:0]     w_half;
    logic [XLEN-1:0] w_ld_ext;
    logic            w_sel_valid;
    logic [4:0]      w_sel_rd;
    logic [XLEN-1:0] w_sel_data;
    logic            r_we;
    logic [4:0]      r_write_addr;
    logic [XLEN-1:0] r_result;

    assign w_ld_acc = ld_valid && ld_ready;
    assign w_half   = ld_addr_lo[1] ? ld_data[31:16] : ld_data[15:0];

    always_comb begin
        w_byte = ld_data[7:0];
        case (ld_addr_lo)
            2'd1:    w_byte = ld_data[15:8];
            2'd2:    w_byte = ld_data[23:16];
            2'd3:    w_byte = ld_data[31:24];
            default: w_byte = ld_data[7:0];
        endcase
    end

    always_comb begin
        w_ld_ext = XLEN'($signed(ld_data));
        case (ld_funct3)
            LD_LB:   w_ld_ext = XLEN'($signed(w_byte));
            LD_LH:   w_ld_ext = XLEN'($signed(w_half));
            LD_LBU:  w_ld_ext = XLEN'(w_byte);
            LD_LHU:  w_ld_ext = XLEN'(w_half);
            default: w_ld_ext = XLEN'($signed(ld_data));
        endcase
    end

`ifdef WB_LD_BUF_EN
    localparam int c_ENT_W = 5 + XLEN;

    logic                           w_push;
    logic                           w_pop;
    logic                           w_full;
    logic                           w_empty;
    logic [c_ENT_W-1:0]             w_head;
    logic [$clog2(BUF_DEPTH+1)-1:0] w_count;

    wb_ld_fifo #(
        .WIDTH (c_ENT_W),
        .DEPTH (BUF_DEPTH)
    ) u_ld_fifo (
        .clk     (clk),
        .clrn    (clrn),
        .i_push  (w_push),
        .i_data  ({ld_rd, w_ld_ext}),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // Full is decoded from the registered count, so ready never depends on inputs.
    assign ld_ready  = !w_full;
    assign buf_count = w_count;

    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_rd    = '0;
        w_sel_data  = '0;
        w_pop       = 1'b0;
        w_push      = w_ld_acc;
        if (alu_valid) begin
            w_sel_valid = 1'b1;
            w_sel_rd    = alu_rd;
            w_sel_data  = alu_data;
        end else if (!w_empty) begin
            w_sel_valid = 1'b1;
            w_sel_rd    = w_head[c_ENT_W-1 -: 5];
            w_sel_data  = w_head[XLEN-1:0];
            w_pop       = 1'b1;
        end else if (w_ld_acc) begin
            w_sel_valid = 1'b1;
            w_sel_rd    = ld_rd;
            w_sel_data  = w_ld_ext;
            w_push      = 1'b0;
        end
    end
`else
    assign ld_ready  = !alu_valid;
    assign buf_count = '0;

    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_rd    = '0;
        w_sel_data  = '0;
        if (alu_valid) begin
            w_sel_valid = 1'b1;
            w_sel_rd    = alu_rd;
            w_sel_data  = alu_data;
        end else if (w_ld_acc) begin
            w_sel_valid = 1'b1;
            w_sel_rd    = ld_rd;
            w_sel_data  = w_ld_ext;
        end
    end
`endif

    // x0 writebacks still retire and update the address/data registers.
    always_ff @(posedge clk) begin
        if (!clrn) begin
            r_we         <= 1'b0;
            r_write_addr <= '0;
            r_result     <= '0;
        end else begin
            r_we <= w_sel_valid && (w_sel_rd != 5'd0);
            if (w_sel_valid) begin
                r_write_addr <= w_sel_rd;
                r_result     <= w_sel_data;
            end
        end
    end

    assign we         = r_we;
    assign write_addr = r_write_addr;
    assign result     = r_result;

endmodule
`default_nettype wire

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32: datapath width.
REQ-002 SHALL have parameter BUF_DEPTH, default 2: load-response buffer entries; legal range 2..8.
REQ-003 SHALL have clk  in  1: single clock; all state updates on posedge clk.
REQ-004 SHALL have clrn  in  1: reset, synchronous and active-low.
REQ-005 SHALL have alu_valid  in  1: ALU result present this cycle; no back-pressure.
REQ-006 SHALL have alu_rd  in  5 and alu_data  in  XLEN: ALU destination register and value.
REQ-007 SHALL have ld_valid  in  1 and ld_ready  out  1: load-response handshake.
REQ-008 SHALL have ld_rd  in  5, ld_data  in  32, ld_funct3  in  3, ld_addr_lo  in  2: load destination, raw memory word, load type, byte offset.
REQ-009 SHALL have we  out  1, write_addr  out  5, result  out  XLEN: register-file write port, all registered.
REQ-010 SHALL have buf_count  out  $clog2(BUF_DEPTH+1): current buffer occupancy.

Function
REQ-011 SHALL accept a load when ld_valid and ld_ready are both high on a posedge; ld_* fields are sampled only then.
REQ-012 SHALL accept the ALU result on every cycle alu_valid is high.
REQ-013 SHALL select one writeback per cycle, in priority order: ALU; buffer head; load accepted this cycle with an empty buffer (direct path).
REQ-014 SHALL drive the selected writeback on we/write_addr/result exactly one cycle after selection.
REQ-015 SHALL push an accepted load into the buffer when the load is not selected that cycle.
REQ-016 SHALL write loads back in acceptance order; no load may overtake an older buffered load.
REQ-017 SHALL drive ld_ready = (buf_count < BUF_DEPTH), a function of registered occupancy only.
REQ-018 SHALL leave buf_count unchanged on a push and a pop in the same cycle, including when the buffer is full.
REQ-019 SHALL drive we low for a selected writeback whose rd is 0, while still consuming the entry; write_addr and result still update.
REQ-020 SHALL drive we low and hold write_addr/result on cycles with no writeback.
REQ-021 SHALL extend load data per ld_funct3: 000 LB sign-extends byte ld_addr_lo; 001 LH sign-extends halfword ld_addr_lo[1]; 010 LW passes the word; 100 LBU and 101 LHU zero-extend; any other code is treated as LW.
REQ-022 SHALL apply the extension before buffering, so entries hold final XLEN values.

Reset
REQ-023 SHALL, while clrn is low at a posedge, set we=0, write_addr=0, result=0, buf_count=0 and buffer pointers to 0.
REQ-024 SHALL discard buffered loads on reset mid-operation; ld_ready SHALL read 1 in the first cycle after reset release.

Configuration
REQ-025 SHALL compile the buffer in with WB_LD_BUF_EN defined, behaving per REQ-013..REQ-018.
REQ-026 SHALL, with WB_LD_BUF_EN undefined, have no buffer: ld_ready = !alu_valid (combinational), an accepted load is written back one cycle later, and buf_count is tied to 0.

Structure
REQ-027 SHALL take from a shared package wb_pkg the load funct3 encodings (LB, LH, LW, LBU, LHU) and the default XLEN.
REQ-028 SHALL implement the buffer as sub-module wb_ld_fifo (synchronous FIFO with push, pop, full, empty and count), instantiated only under WB_LD_BUF_EN.

Verification
REQ-029 Bench SHALL check: alu_valid with rd=5 and data 0x1234 -> next cycle we=1, write_addr=5, result=0x1234.
REQ-030 Bench SHALL check: LB with ld_data 0x0000_8000 and addr_lo=1 -> result 0xFFFF_FF80; LHU with 0xABCD_0000 and addr_lo=2 -> result 0x0000_ABCD.
REQ-031 Bench SHALL check: ALU and load valid together on 3 consecutive cycles, depth 2 -> ALU writes first, ld_ready drops when buf_count=2, then loads drain in order.
REQ-032 Bench SHALL check: ALU result with rd=0 -> we=0 and buf_count unchanged.
REQ-033 Bench SHALL check: clrn low for one cycle with buf_count=2 -> buf_count=0, we=0, ld_ready=1, and no stale load is ever written.
REQ-034 Bench SHALL check, with WB_LD_BUF_EN undefined: alu_valid=1 and ld_valid=1 -> ld_ready=0 and the load is accepted on the first cycle alu_valid=0.
